wb_port_arbiter: RTL

Shares the single register-file write port between the two writeback producers (ALU and data memory). It tracks which destination registers have writes outstanding, so that issue logic can stall on read-after-write hazards. It sits between the execute/memory stages and the register file and drives the file's write address, write data and write qualifier from one registered stage.

---
 rtl/wb_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Purpose : round-robin arbiter sharing one register-file write port between ALU and load writeback, with a RAW scoreboard.
// Latency : 1 cycle; the transfer edge loads wb_*, and the register file commits on the following edge.
// Backpress: ready is withheld only from the loser of a contention; a stalled requester holds valid/rd/data until ready.
// Optional : define WBARB_FORWARD_EN to add rs/rt forwarding outputs from the uncommitted output register.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef WBARB_FORWARD_EN
  ,
  output logic              rs_fwd_hit,
  output logic              rt_fwd_hit,
  output logic [DATA_W-1:0] rs_fwd_data,
  output logic [DATA_W-1:0] rt_fwd_data
`endif
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic            last;        // 0 = ALU granted last, 1 = MEM granted last
  logic            alu_fire;
  logic            mem_fire;
  logic            any_fire;
  logic            grant_wr;    // granted request targets a real register
  wb_req_t         alu_req;
  wb_req_t         mem_req;
  wb_req_t         grant_req;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};

  // Ready depends only on the other requester and the pointer, never on own valid.
  // Under contention exactly one side is ready, so at most one transfer per edge.
  assign alu_ready = !mem_valid || last;
  assign mem_ready = !alu_valid || !last;

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;
  assign any_fire = alu_fire || mem_fire;

  // Select the winning request for the output register and scoreboard clear.
  always_comb begin
    grant_req = alu_req;
    if (mem_fire) begin
      grant_req = mem_req;
    end
  end

  assign grant_wr = any_fire && (grant_req.rd != '0);

  // Round-robin pointer follows whichever side transferred; reset favours ALU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (mem_fire) begin
      last <= 1'b1;
    end else if (alu_fire) begin
      last <= 1'b0;
    end
  end

  // Output register: pulse wb_en per accepted write, hold address/data otherwise.
  // Writes to register 0 are accepted upstream but never qualified here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= grant_wr;
      if (any_fire) begin
        wb_rd   <= grant_req.rd;
        wb_data <= grant_req.data;
      end
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so a new
  // producer of the same register stays outstanding; register 0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (grant_wr) begin
      busy_nxt[grant_req.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; reset discards all outstanding writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

`ifdef WBARB_FORWARD_EN
  // The output register holds a value the register file has not committed yet.
  assign rs_fwd_hit  = wb_en && (wb_rd == rs_addr);
  assign rt_fwd_hit  = wb_en && (wb_rd == rt_addr);
  assign rs_fwd_data = rs_fwd_hit ? wb_data : '0;
  assign rt_fwd_data = rt_fwd_hit ? wb_data : '0;
`endif

endmodule
